// File: rtl/clock_pkg.sv
// Shared definitions for the time/alarm set controller: state encoding,
// field codes, display symbols, BCD bounds and small decode helpers.
package clock_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_E_HOUR = 3'd1,
        S_E_MIN  = 3'd2,
        S_E_SEC  = 3'd3,
        S_E_AMPM = 3'd4,
        S_COMMIT = 3'd5
    } state_t;

    localparam logic [1:0] FLD_HOUR = 2'd0;
    localparam logic [1:0] FLD_MIN  = 2'd1;
    localparam logic [1:0] FLD_SEC  = 2'd2;
    localparam logic [1:0] FLD_AMPM = 2'd3;

    localparam logic [3:0] SYM_AM    = 4'hA;
    localparam logic [3:0] SYM_PM    = 4'hB;
    localparam logic [3:0] SYM_BLANK = 4'hF;

    localparam logic [7:0] HOUR24_LO = 8'h00;
    localparam logic [7:0] HOUR24_HI = 8'h23;
    localparam logic [7:0] HOUR12_LO = 8'h01;
    localparam logic [7:0] HOUR12_HI = 8'h12;
    localparam logic [7:0] MS_LO     = 8'h00;
    localparam logic [7:0] MS_HI     = 8'h59;

    // True when v is a well-formed two-digit BCD value inside [lo, hi].
    function automatic logic bcd2_in_range(input logic [7:0] v,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
    endfunction

    // Field code shown for each state; IDLE and COMMIT report hour (0).
    function automatic logic [1:0] field_of(input state_t s);
        logic [1:0] f;
        case (s)
            S_E_MIN:  f = FLD_MIN;
            S_E_SEC:  f = FLD_SEC;
            S_E_AMPM: f = FLD_AMPM;
            default:  f = FLD_HOUR;
        endcase
        return f;
    endfunction

    // Next edit state on key_next: seconds are skipped for alarms,
    // AM/PM is skipped in 24 h mode.
    function automatic state_t next_field_state(input state_t s,
                                                input logic   alarm,
                                                input logic   h24);
        state_t n;
        case (s)
            S_E_HOUR: n = S_E_MIN;
            S_E_MIN: begin
                if (!alarm)    n = S_E_SEC;
                else if (!h24) n = S_E_AMPM;
                else           n = S_E_HOUR;
            end
            S_E_SEC:  n = h24 ? S_E_HOUR : S_E_AMPM;
            S_E_AMPM: n = S_E_HOUR;
            default:  n = s;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bcd2_wrap.sv
// Combinational two-digit BCD step: increments or decrements i_val by one,
// wrapping from i_hi to i_lo (and back) so the result stays in [lo, hi].
module bcd2_wrap (
    input  logic [7:0] i_val,
    input  logic [7:0] i_lo,
    input  logic [7:0] i_hi,
    input  logic       i_up,
    output logic [7:0] o_val
);

    // Digit-wise BCD carry/borrow with wrap at the bounds.
    always_comb begin
        o_val = i_val;
        if (i_up) begin
            if (i_val >= i_hi)
                o_val = i_lo;
            else if (i_val[3:0] >= 4'd9)
                o_val = {i_val[7:4] + 4'd1, 4'd0};
            else
                o_val = {i_val[7:4], i_val[3:0] + 4'd1};
        end else begin
            if (i_val <= i_lo)
                o_val = i_hi;
            else if (i_val[3:0] == 4'd0)
                o_val = {i_val[7:4] - 4'd1, 4'd9};
            else
                o_val = {i_val[7:4], i_val[3:0] - 4'd1};
        end
    end

endmodule

// File: rtl/set_controller.sv
// Time/alarm set controller. A key_set in IDLE snapshots the live time into
// an edit register; next/inc/dec walk and adjust the fields; a second
// key_set commits with a one-cycle PE pulse; abort or an idle timeout drop
// the edit silently. The raw FSM state is exposed on o_dbg_state.
module set_controller
    import clock_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
) (
    input  logic        CP,
    input  logic        CR,
    input  logic        key_set,
    input  logic        key_next,
    input  logic        key_inc,
    input  logic        key_dec,
    input  logic        key_abort,
    input  logic        mode,
    input  logic        time_mode,
    input  logic [31:0] cur_display,
    output logic [31:0] display_time,
    output logic        PE,
    output logic        mode_out,
    output logic        editing,
    output logic [1:0]  field,
    output logic [2:0]  o_dbg_state
);

    state_t      r_state;
    logic [31:0] r_edit;
    logic        r_alarm;
    logic        r_h24;
    logic [31:0] r_idle_cnt;
    logic        r_pe;
    logic        r_editing;
    logic [1:0]  r_field;

    state_t      w_nxt_state;
    logic [31:0] w_nxt_edit;
    logic [31:0] w_nxt_cnt;
    logic        w_any_key;
    logic        w_enter;
    logic        w_timeout;
    logic [7:0]  w_load_hour_lo;
    logic [7:0]  w_load_hour_hi;
    logic [7:0]  w_load_hour;
    logic [31:0] w_load;
    logic [7:0]  w_step_in;
    logic [7:0]  w_step_lo;
    logic [7:0]  w_step_hi;
    logic [7:0]  w_step_out;
    logic [7:0]  w_suffix_toggled;

    assign w_any_key = key_set | key_next | key_inc | key_dec | key_abort;
    // Abort outranks set, so a simultaneous abort also blocks edit entry.
    assign w_enter   = (r_state == S_IDLE) && key_set && !key_abort;
    assign w_timeout = (r_idle_cnt == TIMEOUT_CYC - 32'd1);

    // Snapshot of cur_display as it should appear at edit entry: illegal
    // hours clamp to the range minimum, alarms have no seconds, 24 h has
    // no suffix and 12 h blanks the upper suffix digit.
    always_comb begin
        w_load_hour_lo = time_mode ? HOUR24_LO : HOUR12_LO;
        w_load_hour_hi = time_mode ? HOUR24_HI : HOUR12_HI;
        w_load_hour    = bcd2_in_range(cur_display[31:24], w_load_hour_lo, w_load_hour_hi)
                         ? cur_display[31:24] : w_load_hour_lo;
        w_load[31:24]  = w_load_hour;
        w_load[23:16]  = cur_display[23:16];
        w_load[15:8]   = mode ? 8'h00 : cur_display[15:8];
        w_load[7:0]    = time_mode ? {SYM_BLANK, SYM_BLANK} : {SYM_BLANK, cur_display[3:0]};
    end

    // Select the byte and bounds for the single shared BCD stepper.
    always_comb begin
        w_step_in = r_edit[31:24];
        w_step_lo = r_h24 ? HOUR24_LO : HOUR12_LO;
        w_step_hi = r_h24 ? HOUR24_HI : HOUR12_HI;
        case (r_state)
            S_E_MIN: begin
                w_step_in = r_edit[23:16];
                w_step_lo = MS_LO;
                w_step_hi = MS_HI;
            end
            S_E_SEC: begin
                w_step_in = r_edit[15:8];
                w_step_lo = MS_LO;
                w_step_hi = MS_HI;
            end
            default: ;
        endcase
    end

    bcd2_wrap u_step (
        .i_val (w_step_in),
        .i_lo  (w_step_lo),
        .i_hi  (w_step_hi),
        .i_up  (key_inc),
        .o_val (w_step_out)
    );

    assign w_suffix_toggled = {r_edit[7:4], (r_edit[3:0] == SYM_AM) ? SYM_PM : SYM_AM};

    // Next-state, edit-register and idle-counter decode with key priority
    // abort > set > next > inc > dec; timeout only fires on a keyless cycle.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_edit  = r_edit;
        w_nxt_cnt   = r_idle_cnt;
        case (r_state)
            S_IDLE: begin
                w_nxt_cnt = 32'd0;
                if (w_enter) begin
                    w_nxt_state = S_E_HOUR;
                    w_nxt_edit  = w_load;
                end
            end
            S_COMMIT: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = 32'd0;
            end
            default: begin
                w_nxt_cnt = w_any_key ? 32'd0 : r_idle_cnt + 32'd1;
                if (key_abort) begin
                    w_nxt_state = S_IDLE;
                end else if (key_set) begin
                    w_nxt_state = S_COMMIT;
                end else if (key_next) begin
                    w_nxt_state = next_field_state(r_state, r_alarm, r_h24);
                end else if (key_inc || key_dec) begin
                    case (r_state)
                        S_E_HOUR: w_nxt_edit[31:24] = w_step_out;
                        S_E_MIN:  w_nxt_edit[23:16] = w_step_out;
                        S_E_SEC:  w_nxt_edit[15:8]  = w_step_out;
                        default:  w_nxt_edit[7:0]   = w_suffix_toggled;
                    endcase
                end else if (w_timeout) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_cnt   = 32'd0;
                end
            end
        endcase
    end

    // State, edit register, latched modes and registered outputs.
    always_ff @(posedge CP) begin
        if (CR) begin
            r_state    <= S_IDLE;
            r_edit     <= 32'h0;
            r_alarm    <= 1'b0;
            r_h24      <= 1'b0;
            r_idle_cnt <= 32'd0;
            r_pe       <= 1'b0;
            r_editing  <= 1'b0;
            r_field    <= FLD_HOUR;
        end else begin
            r_state    <= w_nxt_state;
            r_edit     <= w_nxt_edit;
            r_idle_cnt <= w_nxt_cnt;
            if (w_enter) begin
                r_alarm <= mode;
                r_h24   <= time_mode;
            end
            r_pe       <= (w_nxt_state == S_COMMIT);
            r_editing  <= (w_nxt_state != S_IDLE);
            r_field    <= field_of(w_nxt_state);
        end
    end

    assign display_time = r_editing ? r_edit : cur_display;
    assign PE           = r_pe;
    assign mode_out     = r_alarm;
    assign editing      = r_editing;
    assign field        = r_field;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_set_controller.sv
// Self-checking bench for set_controller. A behavioural model (integer
// hour/min/sec, field index, phase) predicts every cycle; each commit the
// model predicts is queued and a negedge monitor pops it when PE appears.
module tb_set_controller;

    localparam int T = 16;

    logic        CP = 1'b0;
    logic        CR = 1'b0;
    logic        key_set = 1'b0, key_next = 1'b0, key_inc = 1'b0;
    logic        key_dec = 1'b0, key_abort = 1'b0;
    logic        mode = 1'b0, time_mode = 1'b1;
    logic [31:0] cur_display = 32'h0;
    logic [31:0] display_time;
    logic        PE, mode_out, editing;
    logic [1:0]  field;
    logic [2:0]  dbg_state;

    set_controller #(.TIMEOUT_CYC(32'd16)) dut (
        .CP           (CP),
        .CR           (CR),
        .key_set      (key_set),
        .key_next     (key_next),
        .key_inc      (key_inc),
        .key_dec      (key_dec),
        .key_abort    (key_abort),
        .mode         (mode),
        .time_mode    (time_mode),
        .cur_display  (cur_display),
        .display_time (display_time),
        .PE           (PE),
        .mode_out     (mode_out),
        .editing      (editing),
        .field        (field),
        .o_dbg_state  (dbg_state)
    );

    // Clock
    always #5 CP = ~CP;

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] exp_q[$];   // {mode_out, display_time} per expected commit

    // Reference model: phase 0 idle, 1 editing, 2 commit cycle.
    int         m_phase = 0;
    int         m_fld   = 0;
    bit         m_alarm = 0, m_h24 = 0;
    int         m_hour = 0, m_min = 0, m_sec = 0;
    logic [7:0] m_suf = 8'h0;
    int         m_idle = 0;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [31:0] m_word();
        return {to_bcd(m_hour), to_bcd(m_min), to_bcd(m_sec), m_suf};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_enter();
        logic [7:0] hb;
        int lo, hi;
        m_alarm = mode;
        m_h24   = time_mode;
        hb = cur_display[31:24];
        lo = m_h24 ? 0 : 1;
        hi = m_h24 ? 23 : 12;
        if (hb[7:4] <= 4'd9 && hb[3:0] <= 4'd9 && from_bcd(hb) >= lo && from_bcd(hb) <= hi)
            m_hour = from_bcd(hb);
        else
            m_hour = lo;
        m_min  = from_bcd(cur_display[23:16]);
        m_sec  = m_alarm ? 0 : from_bcd(cur_display[15:8]);
        m_suf  = m_h24 ? 8'hFF : {4'hF, cur_display[3:0]};
        m_fld  = 0;
        m_idle = 0;
        m_phase = 1;
    endtask

    task automatic model_adjust(input int dlt);
        case (m_fld)
            0: begin
                if (m_h24) m_hour = (m_hour + dlt + 24) % 24;
                else       m_hour = ((m_hour - 1 + dlt + 12) % 12) + 1;
            end
            1: m_min = (m_min + dlt + 60) % 60;
            2: m_sec = (m_sec + dlt + 60) % 60;
            default: m_suf[3:0] = (m_suf[3:0] == 4'hA) ? 4'hB : 4'hA;
        endcase
    endtask

    task automatic model_step(input bit s, input bit n, input bit i, input bit d,
                              input bit a, input bit cr);
        bit any_key;
        any_key = s | n | i | d | a;
        if (cr) begin
            m_phase = 0; m_fld = 0; m_alarm = 0; m_h24 = 0;
            m_hour = 0; m_min = 0; m_sec = 0; m_suf = 8'h0; m_idle = 0;
            return;
        end
        case (m_phase)
            0: if (s && !a) model_enter();
            1: begin
                if (a) m_phase = 0;
                else if (s) begin
                    exp_q.push_back({m_alarm, m_word()});
                    m_phase = 2;
                end else if (n) begin
                    do m_fld = (m_fld + 1) % 4;
                    while ((m_fld == 2 && m_alarm) || (m_fld == 3 && m_h24));
                end else if (i) model_adjust(1);
                else if (d) model_adjust(-1);
                else if (m_idle == T - 1) m_phase = 0;
                m_idle = any_key ? 0 : m_idle + 1;
            end
            default: begin
                m_phase = 0;
                m_idle  = 0;
            end
        endcase
    endtask

    task automatic check_cycle();
        check("editing", editing, m_phase != 0);
        check("pe_timing", PE, m_phase == 2);
        check("display_time", display_time, (m_phase != 0) ? m_word() : cur_display);
        if (m_phase == 1) check("field", field, m_fld);
        if (m_phase == 0) check("field_idle", field, 0);
    endtask

    // Driver: present keys for one edge, advance the model, then check.
    task automatic step(input bit s, input bit n, input bit i, input bit d,
                        input bit a, input bit cr);
        key_set = s; key_next = n; key_inc = i; key_dec = d; key_abort = a; CR = cr;
        @(posedge CP);
        model_step(s, n, i, d, a, cr);
        #1;
        key_set = 0; key_next = 0; key_inc = 0; key_dec = 0; key_abort = 0; CR = 0;
        check_cycle();
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every PE pulse must match the oldest queued commit.
    always @(negedge CP) begin : monitor
        logic [32:0] e;
        if (PE === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pe: got PE=1 display_time=%h, required no pulse", display_time);
            end else begin
                e = exp_q.pop_front();
                if ({mode_out, display_time} !== e) begin
                    n_fail++;
                    $display("FAIL commit_value: got mode_out=%b display_time=%h expected mode_out=%b display_time=%h",
                             mode_out, display_time, e[32], e[31:0]);
                end
            end
        end
    end

    initial begin : main
        int seq[6] = '{1, 3, 0, 1, 3, 0};
        int cnt;

        // Reset
        cur_display = 32'h11_22_33_FF;
        step(0, 0, 0, 0, 0, 1);
        step(1, 1, 1, 1, 1, 1);
        check("rst_mode_out", mode_out, 0);
        check("rst_field", field, 0);
        check("rst_pe", PE, 0);

        // 24 h hour wrap and commit value
        mode = 0; time_mode = 1; cur_display = 32'h23_59_30_FF;
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        check("h24_wrap", display_time, 32'h00_59_30_FF);
        step(1, 0, 0, 0, 0, 0);
        check("h24_commit_pe", PE, 1);
        check("h24_commit_val", display_time, 32'h00_59_30_FF);
        idle_step();

        // 12 h hour wrap and AM/PM toggle
        mode = 0; time_mode = 0; cur_display = 32'h12_34_56_FA;
        step(1, 0, 0, 0, 0, 0);
        check("h12_load", display_time[31:24], 8'h12);
        step(0, 0, 1, 0, 0, 0);
        check("h12_wrap", display_time[31:24], 8'h01);
        repeat (3) step(0, 1, 0, 0, 0, 0);
        check("h12_field_ampm", field, 3);
        step(0, 0, 0, 1, 0, 0);
        check("h12_suffix", display_time[7:0], 8'hFB);
        step(0, 0, 0, 0, 1, 0);

        // Alarm mode: seconds forced to zero and never visited
        mode = 1; time_mode = 0; cur_display = 32'h07_15_42_FB;
        step(1, 0, 0, 0, 0, 0);
        check("alarm_sec_zero", display_time[15:8], 8'h00);
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0, 0, 0, 0);
            check("alarm_field_seq", field, seq[k]);
        end
        step(1, 0, 0, 0, 0, 0);
        check("alarm_mode_out", mode_out, 1);
        idle_step();

        // Abort in E_MIN
        mode = 0; time_mode = 1; cur_display = 32'h10_20_30_FF;
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check("abort_field_min", field, 1);
        step(0, 0, 0, 0, 1, 0);
        check("abort_editing", editing, 0);
        check("abort_pe", PE, 0);
        idle_step();

        // Timeout: editing drops exactly T cycles after entry
        step(1, 0, 0, 0, 0, 0);
        cnt = 0;
        while (editing === 1'b1 && cnt < 40) begin
            idle_step();
            cnt++;
        end
        check("timeout_cycles", cnt, T);

        // Priority: set wins over inc in the same cycle
        cur_display = 32'h05_06_07_FF;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        check("prio_pe", PE, 1);
        check("prio_val", display_time, 32'h05_06_07_FF);
        idle_step();

        // Reset during E_SEC
        cur_display = 32'h08_09_10_FF;
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check("rst_mid_field_sec", field, 2);
        step(0, 0, 0, 0, 0, 1);
        check("rst_mid_editing", editing, 0);
        check("rst_mid_pe", PE, 0);
        idle_step();
        check("rst_mid_pe_after", PE, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] hb;
            hb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                             : to_bcd($urandom_range(0, 23));
            cur_display = {hb, to_bcd($urandom_range(0, 59)), to_bcd($urandom_range(0, 59)),
                           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            mode      = 1'($urandom_range(0, 1));
            time_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) begin
                repeat (20) idle_step();
            end else begin
                step($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 20,
                     $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25,
                     $urandom_range(0, 99) < 3,  $urandom_range(0, 499) == 0);
            end
        end

        repeat (3) idle_step();
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/set_controller.md
SET_CONTROLLER -- requirements
Module: set_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 32'd50_000_000, the number of idle cycles in an edit state before the edit is abandoned.
REQ-002 SHALL have port CP, input, 1: the single system clock; all state updates on the rising edge.
REQ-003 SHALL have port CR, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have ports key_set, key_next, key_inc, key_dec and key_abort, each input, 1: debounced single-cycle key pulses.
REQ-005 SHALL have port mode, input, 1: 1 = alarm target, 0 = clock target; sampled on edit entry only.
REQ-006 SHALL have port time_mode, input, 1: 1 = 24 h, 0 = 12 h; sampled on edit entry only.
REQ-007 SHALL have port cur_display, input, 32: live time in BCD, laid out as hour[31:24], min[23:16], sec[15:8], suffix[7:0].
REQ-008 SHALL have port display_time, output, 32: the edited value in the same layout, fed to the preset splitter.
REQ-009 SHALL have port PE, output, 1: one-cycle preset-enable pulse.
REQ-010 SHALL have port mode_out, output, 1: the latched mode, valid while PE is high.
REQ-011 SHALL have port editing, output, 1: high in every state except IDLE.
REQ-012 SHALL have port field, output, 2: active field code, 0 = hour, 1 = min, 2 = sec, 3 = AM/PM.

Function
REQ-013 SHALL implement the states IDLE, E_HOUR, E_MIN, E_SEC, E_AMPM and COMMIT.
REQ-014 SHALL, in IDLE on key_set, load cur_display into the edit register, latch mode and time_mode, and go to E_HOUR.
REQ-015 SHALL advance on key_next E_HOUR -> E_MIN -> E_SEC -> E_AMPM -> E_HOUR; E_SEC is skipped when latched mode = 1, and E_AMPM is skipped when latched time_mode = 1.
REQ-016 SHALL go to COMMIT on key_set in any edit state; COMMIT lasts exactly one cycle and then returns to IDLE.
REQ-017 SHALL drive PE = 1 only during COMMIT, so the pulse appears one cycle after the key_set that caused it.
REQ-018 SHALL return to IDLE on key_abort in any edit state, with no PE pulse.
REQ-019 SHALL keep an idle counter that is cleared on any key pulse and on edit entry; when it reaches TIMEOUT_CYC-1 in an edit state, the next state is IDLE with no PE pulse.
REQ-020 SHALL apply key_inc and key_dec to the active field only, as a two-digit BCD wrap: 24 h hour 00..23, 12 h hour 01..12, min and sec 00..59.
REQ-021 SHALL toggle the suffix between 4'hA (AM) and 4'hB (PM) in [3:0] on either key_inc or key_dec while in E_AMPM.
REQ-022 SHALL give priority key_abort > key_set > key_next > key_inc > key_dec when several keys arrive in the same cycle; only the winning key acts.
REQ-023 SHALL force sec to 8'h00 at edit entry when latched mode = 1.
REQ-024 SHALL force suffix to 8'hFF at edit entry when latched time_mode = 1; in 12 h mode, [7:4] = 4'hF.
REQ-025 SHALL, when the loaded hour lies outside the legal range for the latched time_mode, clamp it to the range minimum (00 for 24 h, 01 for 12 h).
REQ-026 SHALL drive display_time from the edit register while editing is high and from cur_display in IDLE.
REQ-027 SHALL drive field = 0 in IDLE.

Reset
REQ-028 SHALL, with CR = 1 at a clock edge, enter IDLE, clear the edit register to 32'h0, and clear the idle counter, mode_out, PE and field to 0.
REQ-029 SHALL let CR override all keys in the same cycle.
REQ-030 SHALL, when CR is asserted during an edit, produce no PE pulse.

Structure
REQ-031 SHALL place the state encoding, field codes and symbol constants (AM 4'hA, PM 4'hB, blank 4'hF) in a shared package clock_pkg.
REQ-032 SHALL use one sub-module, bcd2_wrap, instantiated once: a combinational two-digit BCD up/down step with lo and hi bounds.
REQ-033 SHALL use a single clocked process for the FSM and registers, and no latches.

Verification
REQ-034 SHALL verify 24 h hour wrap: time_mode = 1, cur_display = 32'h23_59_30_FF, key_set, key_inc -> hour 8'h00; then key_set -> PE pulse with display_time = 32'h00_59_30_FF.
REQ-035 SHALL verify 12 h hour wrap and AM/PM toggle: time_mode = 0, hour 12, suffix 8'hFA, key_inc -> hour 01; three key_next, then key_dec -> suffix 8'hFB.
REQ-036 SHALL verify alarm-mode sequencing: mode = 1, key_set -> sec = 8'h00; repeated key_next visits hour, min, AM/PM and never E_SEC; commit -> mode_out = 1 during PE.
REQ-037 SHALL verify key_abort and timeout: key_abort in E_MIN -> IDLE with PE never high; with TIMEOUT_CYC = 16 and no keys, editing falls exactly 16 cycles after entry.
REQ-038 SHALL verify key priority: key_set and key_inc in the same cycle -> commit with the value unchanged.
REQ-039 SHALL verify reset mid-edit: CR = 1 in E_SEC -> next cycle IDLE, editing = 0 and PE = 0.
